// File: rtl/hatch_prefetch.sv
// ---------------------------------------------------------------------------
// hatch_prefetch
//   Instruction prefetcher: walks a byte-addressed fetch pc through a
//   synchronous 48-bit instruction ROM and buffers the returned words, each
//   tagged with its pc, in a DEPTH-entry queue for the decoder.
//
//   A read is issued only when the queue is guaranteed a free slot for its
//   response (credit = count - pop + inflight). Fetches beyond the populated
//   ROM do not strobe the ROM; they travel down the same one-cycle response
//   slot and enter the queue as all-zero words, so ordering and the
//   one-push-per-cycle property are preserved.
//
//   A redirect (or reset) empties the queue, kills the response of any read
//   issued in the previous cycle and restarts fetch at the new target.
//
//   Optional feature macro: HATCH_PREFETCH_FAULT_EN
//     defined   -> output inst_fault flags queue entries fetched from an
//                  index >= ROM_WORDS.
//     undefined -> no inst_fault port; such entries carry 48'h0 only.
// ---------------------------------------------------------------------------
module hatch_prefetch #(
    parameter int          DEPTH     = 4,
    parameter int          ROM_WORDS = 192,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

    output logic        rom_en,
    output logic [7:0]  rom_addr,
    input  logic [47:0] rom_data,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [47:0] inst_data,
    output logic [31:0] inst_pc
`ifdef HATCH_PREFETCH_FAULT_EN
    ,
    output logic        inst_fault
`endif
);

    // Pointer width; count needs one extra bit to represent "full".
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Occupancy arithmetic width: count + inflight can reach DEPTH + 1.
    localparam int OW = PW + 2;

    // Instructions are halfword aligned; bit 0 of any target is dropped.
    localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFE;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   fetch_pc;
    logic [PW:0]   count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Response slot: describes the read issued in the previous cycle.
    logic          inflight;
    logic          inflight_fault;
    logic [31:0]   inflight_pc;

    // Queue storage.
    logic [47:0]   q_data [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
`ifdef HATCH_PREFETCH_FAULT_EN
    logic          q_fault [DEPTH];
`endif

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [31:0]   fetch_idx;
    logic          in_range;
    logic          pop;
    logic          push;
    logic          issue;
    logic [OW-1:0] occupancy;

    // Decode the fetch index, the handshake, and the credit-gated issue.
    always_comb begin
        // NOTE: every signal gets a default before any conditional logic so
        // no path leaves it unassigned and no latch is inferred.
        fetch_idx  = fetch_pc >> 1;
        in_range   = (fetch_idx < 32'(ROM_WORDS));

        // Head is hidden during reset and redirect so nothing transfers in
        // a cycle whose queue contents are about to be discarded.
        inst_valid = (count != '0) && !redirect_valid && !rst;
        pop        = inst_valid && inst_ready;

        // A surviving response always lands; kill is applied in the
        // sequential block, where rst and redirect take priority.
        push       = inflight;

        // inst_ready reaches issue only through this credit term.
        occupancy  = OW'(count) + OW'(inflight) - OW'(pop);
        issue      = !rst && !redirect_valid && (occupancy < OW'(DEPTH));

        rom_en     = issue && in_range;
        rom_addr   = fetch_idx[7:0];
    end

    // Head entry, read straight out of storage.
    always_comb begin
        inst_data = q_data[rd_ptr];
        inst_pc   = q_pc[rd_ptr];
`ifdef HATCH_PREFETCH_FAULT_EN
        inst_fault = q_fault[rd_ptr];
`endif
    end

    // ------------------------------------------------------------------
    // Sequential control
    // ------------------------------------------------------------------

    // Fetch pc, response slot, pointers and count; rst beats redirect.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            fetch_pc       <= RESET_PC_ALIGNED;
            count          <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            inflight       <= 1'b0;
            inflight_fault <= 1'b0;
            inflight_pc    <= RESET_PC_ALIGNED;
        end else if (redirect_valid) begin
            fetch_pc       <= redirect_pc & PC_ALIGN_MASK;
            count          <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            inflight       <= 1'b0;
            inflight_fault <= 1'b0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd2;
            end

            inflight       <= issue;
            inflight_fault <= !in_range;
            inflight_pc    <= fetch_pc;

            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue write port: capture the response (or a zero word for an
    // out-of-range fetch) unless it is being killed this cycle.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; an entry is only observed once count
        // covers it, so its power-up contents are never visible.
        if (!rst && !redirect_valid && push) begin
            q_data[wr_ptr]  <= inflight_fault ? 48'h0 : rom_data;
            q_pc[wr_ptr]    <= inflight_pc;
`ifdef HATCH_PREFETCH_FAULT_EN
            q_fault[wr_ptr] <= inflight_fault;
`endif
        end
    end

endmodule

// File: tb/tb_hatch_prefetch.sv
// ---------------------------------------------------------------------------
// tb_hatch_prefetch
//   Self-checking bench for hatch_prefetch with a behavioural synchronous
//   ROM. Every restart of fetch (reset or redirect) reloads a scoreboard with
//   the instruction stream the prefetcher must deliver from that target; a
//   monitor pops and compares on each accepted transfer. Hand-written
//   sequences cover latency, stall, kill and reset corners; a vector table
//   covers redirect targets including ROM-end and 32-bit wrap boundaries.
//   Build with +define+HATCH_PREFETCH_FAULT_EN to also check inst_fault.
// ---------------------------------------------------------------------------
module tb_hatch_prefetch;

    localparam int ROM_WORDS = 192;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [47:0] rom_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [47:0] inst_data;
    logic [31:0] inst_pc;
`ifdef HATCH_PREFETCH_FAULT_EN
    logic        inst_fault;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hatch_prefetch #(
        .DEPTH     (4),
        .ROM_WORDS (ROM_WORDS),
        .RESET_PC  (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
`ifdef HATCH_PREFETCH_FAULT_EN
        ,
        .inst_fault     (inst_fault)
`endif
    );

    // Distinct, address-dependent ROM contents.
    function automatic logic [47:0] rom_word(input logic [7:0] a);
        return {a, 8'h3C, ~a, a ^ 8'h96, a + 8'h01, 8'hE7};
    endfunction

    // Synchronous ROM: data valid the cycle after rom_en, junk otherwise.
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
        else        rom_data <= 48'hBAD0_BAD0_BAD0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [47:0] data;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    int          deliv_cnt  = 0;
    logic        got_first  = 1'b0;
    logic [31:0] first_pc   = 32'h0;
    int          rom_en_cnt = 0;
    int          oor_cnt    = 0;

    // Expected stream after fetch restarts at pc.
    task automatic sb_restart(input logic [31:0] pc);
        logic [31:0] p;
        exp_t        e;
        sb.delete();
        p = pc & 32'hFFFF_FFFE;
        for (int i = 0; i < 80; i++) begin
            e.pc    = p;
            e.fault = ((p >> 1) >= 32'(ROM_WORDS));
            e.data  = e.fault ? 48'h0 : rom_word(p[8:1]);
            sb.push_back(e);
            p = p + 32'd2;
        end
        deliv_cnt = 0;
        got_first = 1'b0;
        first_pc  = 32'h0;
    endtask

    // Monitor: compare every accepted transfer; count ROM strobes.
    always @(negedge clk) begin
        exp_t e;
        if (inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("deliver_pc", inst_pc, e.pc);
                check("deliver_data", inst_data, e.data);
`ifdef HATCH_PREFETCH_FAULT_EN
                check("deliver_fault", inst_fault, e.fault);
`endif
            end
            if (!got_first) begin
                got_first = 1'b1;
                first_pc  = inst_pc;
            end
            deliv_cnt++;
        end
        if (rom_en) begin
            rom_en_cnt++;
            if (rom_addr >= 8'(ROM_WORDS)) oor_cnt++;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Redirect vectors: target, cycles run after the redirect cycle,
    // expected first delivered pc and number of deliveries (cycles - 2).
    typedef struct {
        logic [31:0] tgt;
        int          cycles;
        logic [31:0] exp_first;
        int          exp_n;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;

        vecs[0] = '{32'h0000_0040, 8,  32'h0000_0040, 6};
        vecs[1] = '{32'h0000_017E, 6,  32'h0000_017E, 4};
        vecs[2] = '{32'h0000_0011, 5,  32'h0000_0010, 3};
        vecs[3] = '{32'h0000_0002, 10, 32'h0000_0002, 8};
        vecs[4] = '{32'hFFFF_FFFE, 5,  32'hFFFF_FFFE, 3};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        sb_restart(32'h0);

        // Reset state.
        next_cycle();
        @(negedge clk);
        check("reset_rom_en", rom_en, 0);
        check("reset_inst_valid", inst_valid, 0);
        next_cycle();

        // Reset release with ready held: one read and one pc per cycle.
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("stream_rom_en", rom_en, 1);
            check("stream_rom_addr", rom_addr, c);
            check("stream_valid", inst_valid, c >= 2);
            if (c >= 2) check("stream_pc", inst_pc, 2 * (c - 2));
            next_cycle();
        end

        // Stall from reset release: four credits, then head held stable.
        rst        = 1'b1;
        inst_ready = 1'b0;
        sb_restart(32'h0);
        next_cycle();
        next_cycle();
        rst        = 1'b0;
        rom_en_cnt = 0;
        stable     = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 2 && (inst_valid !== 1'b1 || inst_pc !== 32'h0 ||
                           inst_data !== rom_word(8'h0)))
                stable = 1'b0;
            next_cycle();
        end
        check("stall_read_count", rom_en_cnt, 4);
        check("stall_head_stable", stable, 1);
        inst_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("drain_valid", inst_valid, 1);
            check("drain_pc", inst_pc, 2 * c);
            next_cycle();
        end

        // Redirect with three entries queued and a read inflight.
        rst        = 1'b1;
        inst_ready = 1'b0;
        sb_restart(32'h0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        repeat (4) next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        inst_ready     = 1'b1;
        sb_restart(32'h40);
        @(negedge clk);
        check("redir_valid_gated", inst_valid, 0);
        check("redir_no_rom_en", rom_en, 0);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("redir_n1_rom_en", rom_en, 1);
        check("redir_n1_rom_addr", rom_addr, 8'h20);
        check("redir_n1_valid", inst_valid, 0);
        next_cycle();
        @(negedge clk);
        check("redir_n2_valid", inst_valid, 0);
        next_cycle();
        @(negedge clk);
        check("redir_n3_valid", inst_valid, 1);
        check("redir_n3_pc", inst_pc, 32'h40);
        next_cycle();

        // Back-to-back redirects: last one wins.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        sb_restart(32'h10);
        next_cycle();
        redirect_pc = 32'h20;
        sb_restart(32'h20);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("b2b_rom_addr", rom_addr, 8'h10);
        check("b2b_valid_a", inst_valid, 0);
        next_cycle();
        @(negedge clk);
        check("b2b_valid_b", inst_valid, 0);
        next_cycle();
        @(negedge clk);
        check("b2b_valid", inst_valid, 1);
        check("b2b_first_pc", inst_pc, 32'h20);
        next_cycle();

        // Redirect kills the read issued in the previous cycle.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        sb_restart(32'h10);
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("kill_rom_en", rom_en, 1);
        check("kill_rom_addr", rom_addr, 8'h08);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h60;
        sb_restart(32'h60);
        next_cycle();
        redirect_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("kill_valid_low", inst_valid, 0);
            next_cycle();
        end
        @(negedge clk);
        check("kill_first_pc", inst_pc, 32'h60);
        next_cycle();

        // Vector table of redirect targets.
        for (int v = 0; v < 5; v++) begin
            redirect_valid = 1'b1;
            redirect_pc    = vecs[v].tgt;
            inst_ready     = 1'b1;
            sb_restart(vecs[v].tgt);
            next_cycle();
            redirect_valid = 1'b0;
            repeat (vecs[v].cycles) next_cycle();
            check("vec_deliv_count", deliv_cnt, vecs[v].exp_n);
            check("vec_first_pc", first_pc, vecs[v].exp_first);
        end

        // Fill the queue, then reset together with a redirect.
        inst_ready = 1'b0;
        repeat (8) next_cycle();
        @(negedge clk);
        check("full_valid", inst_valid, 1);
        check("full_no_rom_en", rom_en, 0);
        next_cycle();
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        sb_restart(32'h0);
        @(negedge clk);
        check("rst_valid", inst_valid, 0);
        check("rst_rom_en", rom_en, 0);
        next_cycle();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        @(negedge clk);
        check("post_rst_valid", inst_valid, 0);
        check("post_rst_rom_en", rom_en, 1);
        check("post_rst_rom_addr", rom_addr, 8'h00);
        next_cycle();
        repeat (6) next_cycle();
        check("post_rst_deliv_count", deliv_cnt, 5);
        check("post_rst_first_pc", first_pc, 32'h0);

        check("rom_en_out_of_range", oor_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
